// File: rtl/spi_rx_sampler.sv
// SPI frame receiver in the system clock domain: oversamples sclk/cs/mosi, rebuilds
// LSB-first words and buffers them in a first-word-fall-through FIFO.
module spi_rx_sampler #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sclk,
  input  logic                          i_cs,
  input  logic                          i_mosi,
  output logic [DATA_W-1:0]             o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned BitW   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv} state_e;

  state_e              r_state;
  logic                r_sclk_m, r_sclk_s, r_sclk_d;
  logic                r_cs_m, r_cs_s;
  logic                r_mosi_m, r_mosi_s;
  logic [DATA_W-1:0]   r_sr;
  logic [BitW-1:0]     r_cnt;
  logic                r_frame_err;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CountW-1:0]   r_count;

  logic                w_fall;
  logic [DATA_W-1:0]   w_sr_next;
  logic [BitW-1:0]     w_cnt_next;
  logic                w_push, w_pop, w_full, w_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_m <= 1'b0;
      r_sclk_s <= 1'b0;
      r_sclk_d <= 1'b0;
      r_cs_m   <= 1'b1;
      r_cs_s   <= 1'b1;
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
    end else begin
      r_sclk_m <= i_sclk;
      r_sclk_s <= r_sclk_m;
      r_sclk_d <= r_sclk_s;
      r_cs_m   <= i_cs;
      r_cs_s   <= r_cs_m;
      r_mosi_m <= i_mosi;
      r_mosi_s <= r_mosi_m;
    end
  end

  // Sample lands before the frame-close decision so a same-cycle cs rise still counts it.
  always_comb begin
    w_fall     = r_sclk_d & ~r_sclk_s;
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    if (w_fall) begin
      w_sr_next = {r_mosi_s, r_sr[DATA_W-1:1]};
      if (r_cnt != BitW'(DATA_W)) w_cnt_next = r_cnt + BitW'(1);
    end
    w_push = (r_state == StRecv) && r_cs_s && (w_cnt_next == BitW'(DATA_W));
    w_pop  = o_out_valid && i_out_ready;
    w_full = (r_count == CountW'(FIFO_DEPTH));
    w_wr   = w_push && (!w_full || w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StWaitIdle;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      unique case (r_state)
        StWaitIdle: if (r_cs_s) r_state <= StIdle;
        StIdle: begin
          r_sr  <= '0;
          r_cnt <= '0;
          if (!r_cs_s) r_state <= StRecv;
        end
        StRecv: begin
          r_sr  <= w_sr_next;
          r_cnt <= w_cnt_next;
          if (r_cs_s) begin
            r_frame_err <= (w_cnt_next != BitW'(DATA_W));
            r_state     <= StIdle;
          end
        end
        default: r_state <= StWaitIdle;
      endcase
    end
  end

  // When full, a simultaneous pop frees the head slot, which is also the write slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_sr_next;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CountW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CountW'(1);
    end
  end

  assign o_out_data   = r_mem[r_rd_ptr];
  assign o_out_valid  = (r_count != '0);
  assign o_fifo_count = r_count;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_spi_rx_sampler.sv
// Directed bench for spi_rx_sampler: drives SPI frames like spi_master and checks
// received words, FIFO occupancy, latency, frame errors and overflow.
module tb_spi_rx_sampler;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst, sclk, cs, mosi, out_ready;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid, frame_err, overflow;
  logic [2:0]           fifo_count;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int base_ferr, base_ovf, lat;

  spi_rx_sampler #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sclk       (sclk),
    .i_cs         (cs),
    .i_mosi       (mosi),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_fifo_count (fifo_count),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  // Master changes mosi on the sclk rising edge; the receiver samples on the fall.
  task automatic spi_edge(input logic b);
    sclk = 1'b1;
    mosi = b;
    half();
    sclk = 1'b0;
    half();
  endtask

  task automatic spi_start();
    repeat (8) @(negedge clk);
    cs = 1'b0;
    half();
    spi_edge(1'b1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    spi_start();
    for (int i = 0; i < DATA_W; i++) spi_edge(w[i]);
    cs = 1'b1;
  endtask

  task automatic expect_pop(input string tag, input logic [DATA_W-1:0] exp);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_data", out_data, 12'h000);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single word, consumer always ready
    out_ready = 1'b1;
    send_word(12'hA5C);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 4);
    check("t1_data", out_data, 12'hA5C);
    @(negedge clk);
    check("t1_valid_drop", out_valid, 1'b0);
    check("t1_count", fifo_count, 3'd0);
    out_ready = 1'b0;

    // Three buffered words, popped in order
    send_word(12'h001);
    send_word(12'h800);
    send_word(12'hFFF);
    repeat (6) @(negedge clk);
    check("t2_count", fifo_count, 3'd3);
    expect_pop("t2_pop0", 12'h001);
    expect_pop("t2_pop1", 12'h800);
    expect_pop("t2_pop2", 12'hFFF);
    check("t2_empty", out_valid, 1'b0);

    // Overflow on the fifth word
    base_ovf = ovf_cnt;
    send_word(12'h123);
    send_word(12'h456);
    send_word(12'h789);
    send_word(12'hABC);
    repeat (6) @(negedge clk);
    check("t3_ovf_before", ovf_cnt - base_ovf, 0);
    send_word(12'hDEF);
    repeat (6) @(negedge clk);
    check("t3_ovf", ovf_cnt - base_ovf, 1);
    check("t3_count", fifo_count, 3'd4);
    expect_pop("t3_pop0", 12'h123);
    expect_pop("t3_pop1", 12'h456);
    expect_pop("t3_pop2", 12'h789);
    expect_pop("t3_pop3", 12'hABC);
    check("t3_empty", fifo_count, 3'd0);

    // Short frame: 7 sclk periods
    base_ferr = ferr_cnt;
    spi_start();
    for (int i = 0; i < 6; i++) spi_edge(1'b1);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_ferr", ferr_cnt - base_ferr, 1);
    check("t4_count", fifo_count, 3'd0);

    // Reset in the middle of a frame
    spi_start();
    for (int i = 0; i < 6; i++) spi_edge(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) spi_edge(1'b1);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_count", fifo_count, 3'd0);
    check("t5_valid", out_valid, 1'b0);
    send_word(12'h3C3);
    repeat (6) @(negedge clk);
    check("t5_count1", fifo_count, 3'd1);
    expect_pop("t5_pop", 12'h3C3);

    // Full FIFO: pop and push land on the same clock edge
    send_word(12'h111);
    send_word(12'h222);
    send_word(12'h333);
    send_word(12'h444);
    repeat (6) @(negedge clk);
    check("t6_full", fifo_count, 3'd4);
    base_ovf = ovf_cnt;
    send_word(12'h555);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_ovf", ovf_cnt - base_ovf, 0);
    check("t6_count", fifo_count, 3'd4);
    expect_pop("t6_pop0", 12'h222);
    expect_pop("t6_pop1", 12'h333);
    expect_pop("t6_pop2", 12'h444);
    expect_pop("t6_pop3", 12'h555);
    check("t6_empty", fifo_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
